// File: rtl/hbridge_dir_sequencer.sv
// H-bridge direction sequencer for one L298-style channel.
// Takes the 2-bit direction code and a duty word. Drives IN1/IN2/EN.
// Every polarity change passes through a coast (dead-time) interval.
// EN is a free-running PWM whose duty is only picked up at period start,
// so a duty change never produces a runt pulse.
// All outputs are registered. They are computed from the next state so that
// they change on the same edge as the FSM.
module hbridge_dir_sequencer #(
  parameter int PWM_WIDTH       = 8,
  parameter int DEADTIME_CYCLES = 500,
  parameter int DT_WIDTH        = 10
) (
  input  logic                 HBRIDGE_SEQ_CLOCK_50,
  input  logic                 HBRIDGE_SEQ_RESET_InHigh,
  input  logic [1:0]           HBRIDGE_SEQ_CONTROL_InBus,
  input  logic [PWM_WIDTH-1:0] HBRIDGE_SEQ_DUTY_InBus,
  output logic                 HBRIDGE_SEQ_IN1_Out,
  output logic                 HBRIDGE_SEQ_IN2_Out,
  output logic                 HBRIDGE_SEQ_EN_Out,
  output logic                 HBRIDGE_SEQ_BUSY_Out
);

  typedef enum logic [1:0] {
    ST_BRAKE = 2'd0,
    ST_FWD   = 2'd1,
    ST_REV   = 2'd2,
    ST_DEAD  = 2'd3
  } state_t;

  localparam logic [DT_WIDTH-1:0] DEAD_LAST = DT_WIDTH'(DEADTIME_CYCLES - 1);

  logic                 clk;
  logic                 rst;
  logic [1:0]           req_q;
  state_t               state, state_d;
  state_t               target, target_d;
  state_t               req;
  logic [DT_WIDTH-1:0]  dead_cnt, dead_cnt_d;
  logic [PWM_WIDTH-1:0] pwm_cnt, pwm_cnt_d;
  logic [PWM_WIDTH-1:0] duty_q, duty_d;
  logic                 pwm_d;

  assign clk = HBRIDGE_SEQ_CLOCK_50;
  assign rst = HBRIDGE_SEQ_RESET_InHigh;

  // Codes 01/10 select a rotation sense; 11 and 00 both mean brake.
  function automatic state_t decode_req(input logic [1:0] code);
    case (code)
      2'b01:   return ST_FWD;
      2'b10:   return ST_REV;
      default: return ST_BRAKE;
    endcase
  endfunction

  assign req = decode_req(req_q);

  // Register the direction code once so that the FSM acts on a stable request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_q <= 2'b11;
    else     req_q <= HBRIDGE_SEQ_CONTROL_InBus;
  end

  // FSM state, dead-time target and dead-time counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_DEAD;
      target   <= ST_BRAKE;
      dead_cnt <= '0;
    end else begin
      state    <= state_d;
      target   <= target_d;
      dead_cnt <= dead_cnt_d;
    end
  end

  // Next state: brake is always reachable at once; polarity changes coast first.
  always_comb begin
    state_d    = state;
    target_d   = target;
    dead_cnt_d = dead_cnt;
    case (state)
      ST_BRAKE: begin
        if (req != ST_BRAKE) begin
          state_d    = ST_DEAD;
          target_d   = req;
          dead_cnt_d = '0;
        end
      end
      ST_FWD, ST_REV: begin
        if (req == ST_BRAKE) begin
          state_d = ST_BRAKE;
        end else if (req != state) begin
          state_d    = ST_DEAD;
          target_d   = req;
          dead_cnt_d = '0;
        end
      end
      default: begin
        // A brake request aborts a pending polarity. The post-reset coast
        // toward brake still runs its full length.
        if (req == ST_BRAKE && target != ST_BRAKE) begin
          state_d    = ST_BRAKE;
          dead_cnt_d = '0;
        end else if (req != ST_BRAKE && req != target) begin
          target_d   = req;
          dead_cnt_d = '0;
        end else if (dead_cnt == DEAD_LAST) begin
          state_d    = target;
          dead_cnt_d = '0;
        end else begin
          dead_cnt_d = dead_cnt + 1'b1;
        end
      end
    endcase
  end

  // Next PWM counter, the duty for that count, and the resulting PWM level.
  always_comb begin
    pwm_cnt_d = pwm_cnt + 1'b1;
    duty_d    = (pwm_cnt_d == '0) ? HBRIDGE_SEQ_DUTY_InBus : duty_q;
    pwm_d     = (pwm_cnt_d < duty_d);
  end

  // Free-running PWM counter. The duty is latched only when the counter wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty_q  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt_d;
      duty_q  <= duty_d;
    end
  end

  // Registered bridge outputs, decoded from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      HBRIDGE_SEQ_IN1_Out  <= 1'b0;
      HBRIDGE_SEQ_IN2_Out  <= 1'b0;
      HBRIDGE_SEQ_EN_Out   <= 1'b0;
      HBRIDGE_SEQ_BUSY_Out <= 1'b1;
    end else begin
      case (state_d)
        ST_BRAKE: begin
          HBRIDGE_SEQ_IN1_Out  <= 1'b1;
          HBRIDGE_SEQ_IN2_Out  <= 1'b1;
          HBRIDGE_SEQ_EN_Out   <= 1'b1;
          HBRIDGE_SEQ_BUSY_Out <= 1'b0;
        end
        ST_FWD: begin
          HBRIDGE_SEQ_IN1_Out  <= 1'b1;
          HBRIDGE_SEQ_IN2_Out  <= 1'b0;
          HBRIDGE_SEQ_EN_Out   <= pwm_d;
          HBRIDGE_SEQ_BUSY_Out <= 1'b0;
        end
        ST_REV: begin
          HBRIDGE_SEQ_IN1_Out  <= 1'b0;
          HBRIDGE_SEQ_IN2_Out  <= 1'b1;
          HBRIDGE_SEQ_EN_Out   <= pwm_d;
          HBRIDGE_SEQ_BUSY_Out <= 1'b0;
        end
        default: begin
          HBRIDGE_SEQ_IN1_Out  <= 1'b0;
          HBRIDGE_SEQ_IN2_Out  <= 1'b0;
          HBRIDGE_SEQ_EN_Out   <= 1'b0;
          HBRIDGE_SEQ_BUSY_Out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hbridge_dir_sequencer.sv
// Bench for hbridge_dir_sequencer with PWM_WIDTH=4 and DEADTIME_CYCLES=4.
// A behavioural model predicts {IN1,IN2,EN,BUSY} after every clock edge and
// queues the prediction. A monitor pops the prediction on the falling edge and
// compares it against the design.
module tb_hbridge_dir_sequencer;

  localparam int PW   = 4;
  localparam int DT   = 4;
  localparam int NPER = 1 << PW;

  logic          clk;
  logic          rst;
  logic [1:0]    ctrl;
  logic [PW-1:0] duty;
  logic          in1, in2, en, busy;

  int check_count;
  int error_count;

  logic [3:0] exp_q[$];

  // Model state, kept as the behaviour description: a drive mode, a coast
  // with a goal and a number of coast clocks left, and PWM phase from edge count.
  int         m_mode;
  bit         m_coast;
  int         m_goal;
  int         m_left;
  logic [1:0] m_req;
  int         m_edges;
  int         m_duty;
  logic [3:0] m_last;
  logic [1:0] prev_pair;
  bit         prev_valid;

  hbridge_dir_sequencer #(
    .PWM_WIDTH(PW),
    .DEADTIME_CYCLES(DT),
    .DT_WIDTH(3)
  ) dut (
    .HBRIDGE_SEQ_CLOCK_50(clk),
    .HBRIDGE_SEQ_RESET_InHigh(rst),
    .HBRIDGE_SEQ_CONTROL_InBus(ctrl),
    .HBRIDGE_SEQ_DUTY_InBus(duty),
    .HBRIDGE_SEQ_IN1_Out(in1),
    .HBRIDGE_SEQ_IN2_Out(in2),
    .HBRIDGE_SEQ_EN_Out(en),
    .HBRIDGE_SEQ_BUSY_Out(busy)
  );

  // 10 ns clock. Inputs change on the falling edge, so they are stable at the rising edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 0 = brake, 1 = forward, 2 = reverse.
  function automatic int kind(input logic [1:0] c);
    case (c)
      2'b01:   return 1;
      2'b10:   return 2;
      default: return 0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s t=%0t actual(in1,in2,en,busy)=%b expected=%b", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] c, input logic [PW-1:0] d, input int cycles);
    ctrl = c;
    duty = d;
    repeat (cycles) @(negedge clk);
  endtask

  // Reference model: one step per rising edge. It uses the request seen at the
  // previous edge, which gives the one-clock input registration.
  initial begin
    forever begin
      int r;
      int phase;
      bit pwm;
      @(posedge clk);
      if (rst) begin
        m_coast = 1'b1;
        m_left  = DT;
        m_goal  = 0;
        m_mode  = 0;
        m_req   = 2'b11;
        m_edges = 0;
        m_duty  = 0;
        m_last  = 4'b0001;
      end else begin
        r = kind(m_req);
        if (m_coast) begin
          if (r == 0 && m_goal != 0) begin
            m_coast = 1'b0;
            m_mode  = 0;
          end else if (r != 0 && r != m_goal) begin
            m_goal = r;
            m_left = DT;
          end else begin
            m_left--;
            if (m_left == 0) begin
              m_coast = 1'b0;
              m_mode  = m_goal;
            end
          end
        end else if (r == 0) begin
          m_mode = 0;
        end else if (r != m_mode) begin
          m_coast = 1'b1;
          m_goal  = r;
          m_left  = DT;
        end
        m_req = ctrl;
        m_edges++;
        phase = m_edges % NPER;
        if (phase == 0) m_duty = int'(duty);
        pwm = (phase < m_duty);
        if (m_coast)          m_last = 4'b0001;
        else if (m_mode == 0) m_last = 4'b1110;
        else if (m_mode == 1) m_last = {2'b10, pwm, 1'b0};
        else                  m_last = {2'b01, pwm, 1'b0};
      end
      exp_q.push_back(m_last);
    end
  end

  // Monitor: compares each queued prediction. It also checks that IN1/IN2
  // never flips directly between the two polarities.
  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput("scoreboard", {in1, in2, en, busy}, exp_q.pop_front());
    if (prev_valid && {in1, in2} != prev_pair) begin
      check_count++;
      if ((prev_pair == 2'b10 && {in1, in2} == 2'b01) || (prev_pair == 2'b01 && {in1, in2} == 2'b10)) begin
        error_count++;
        $display("[TB] FAIL polarity_flip t=%0t actual=%b->%b required=coast between", $time, prev_pair, {in1, in2});
      end
    end
    prev_pair  <= {in1, in2};
    prev_valid <= 1'b1;
  end

  initial begin
    check_count = 0;
    error_count = 0;
    prev_valid  = 1'b0;
    prev_pair   = 2'b00;
    rst  = 1'b1;
    ctrl = 2'b11;
    duty = '0;
    m_edges = 0;
    m_last  = 4'b0001;
    #1;
    checkOutput("reset_async", {in1, in2, en, busy}, 4'b0001);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Post-reset coast then brake, with brake requested.
    applyStimulus(2'b11, 4'd0, 10);
    // Brake to forward at duty 4.
    applyStimulus(2'b01, 4'd4, 40);
    // Forward to reverse.
    applyStimulus(2'b10, 4'd4, 30);
    // Retarget while coasting, then abort a coast with brake.
    applyStimulus(2'b01, 4'd4, 4);
    applyStimulus(2'b10, 4'd4, 14);
    applyStimulus(2'b01, 4'd4, 3);
    applyStimulus(2'b11, 4'd4, 8);
    // Duty change 4 -> 12 in the middle of a period.
    applyStimulus(2'b01, 4'd4, 40);
    for (int k = 0; k < 20 && (m_edges % NPER) != 7; k++) @(negedge clk);
    check_count++;
    if ((m_edges % NPER) != 7) begin
      error_count++;
      $display("[TB] FAIL phase_wait actual=%0d required=7", m_edges % NPER);
    end
    applyStimulus(2'b01, 4'd12, 40);
    // Duty extremes.
    applyStimulus(2'b01, 4'd0, 40);
    applyStimulus(2'b01, 4'd15, 40);

    // Random control codes and duties with short holds.
    for (int i = 0; i < 200; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), PW'($urandom_range(0, NPER - 1)), $urandom_range(1, 12));
    end

    // Reverse with PWM high, then an asynchronous reset in the middle of a cycle.
    applyStimulus(2'b10, 4'd15, 30);
    for (int k = 0; k < 40 && m_last != 4'b0110; k++) @(negedge clk);
    check_count++;
    if (m_last != 4'b0110) begin
      error_count++;
      $display("[TB] FAIL rev_pwm_wait actual=%b required=0110", m_last);
    end
    #1 rst = 1'b1;
    #1 checkOutput("reset_mid_run", {in1, in2, en, busy}, 4'b0001);
    ctrl = 2'b11;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    applyStimulus(2'b11, 4'd15, 10);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/hbridge_dir_sequencer.md
Name: hbridge_dir_sequencer

Overview:
- Downstream stage of the wheel direction detector.
- Consumes the 2-bit direction control code (01 = one rotation sense, 10 = the other, 11 = fast stop) plus a duty word from the speed controller.
- Drives one L298-style H-bridge channel (IN1, IN2, EN).
- Enforces a coast dead-time on every polarity change, and generates the enable PWM with glitch-free duty updates.

Parameters:
- PWM_WIDTH, 8, width of the duty word and PWM counter; PWM period = 2^PWM_WIDTH clocks.
- DEADTIME_CYCLES, 500, clocks spent coasting between polarities (10 us at 50 MHz); must be >= 1.
- DT_WIDTH, 10, width of the dead-time counter; must satisfy 2^DT_WIDTH > DEADTIME_CYCLES.

Ports:
- HBRIDGE_SEQ_CLOCK_50  input  1  system clock, rising-edge.
- HBRIDGE_SEQ_RESET_InHigh  input  1  reset, asynchronous, active-high.
- HBRIDGE_SEQ_CONTROL_InBus  input  2  direction code: 01 FWD, 10 REV, 11 BRAKE, 00 treated as BRAKE.
- HBRIDGE_SEQ_DUTY_InBus  input  PWM_WIDTH  requested PWM duty, unsigned.
- HBRIDGE_SEQ_IN1_Out  output  1  bridge input 1.
- HBRIDGE_SEQ_IN2_Out  output  1  bridge input 2.
- HBRIDGE_SEQ_EN_Out  output  1  bridge enable (PWM).
- HBRIDGE_SEQ_BUSY_Out  output  1  high while in DEAD state.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-high.
- Reset state: all outputs are registered. During reset IN1=0, IN2=0, EN=0, BUSY=1. FSM=DEAD, target=BRAKE, dead counter=0, PWM counter=0, latched duty=0.
- Input registration: CONTROL is registered once (req_q). The FSM acts on req_q.
- Latency: a CONTROL change before edge N is in req_q after N. The FSM/outputs update at edge N+1.
- FSM states: BRAKE, FWD, REV, DEAD.
  - BRAKE: IN1=1, IN2=1, EN=1 (constant, not PWM).
  - FWD: IN1=1, IN2=0, EN=pwm.
  - REV: IN1=0, IN2=1, EN=pwm.
  - DEAD: IN1=0, IN2=0, EN=0, BUSY=1.
- Transitions:
  - Any state, req = BRAKE (11/00): go to BRAKE next edge, no dead-time (brake is always safe).
  - BRAKE, req FWD or REV: go to DEAD with target=req and counter=0.
  - FWD, req REV (or REV, req FWD): go to DEAD with target=req and counter=0.
  - FWD, req FWD / REV, req REV: stay.
  - DEAD: counter increments each clock. When counter == DEADTIME_CYCLES-1, go to the target state next edge. DEAD therefore lasts exactly DEADTIME_CYCLES clocks.
  - DEAD, req differs from target and is not BRAKE: target=req, counter restarts at 0.
  - DEAD, req = BRAKE: leave immediately to BRAKE (the abort rule above applies).
- PWM:
  - The PWM counter is free-running, PWM_WIDTH bits, and wraps 2^PWM_WIDTH-1 -> 0.
  - Latched duty is loaded from the duty input only on the cycle the counter wraps to 0. Mid-period duty changes take effect at the next period start.
  - pwm = (counter < latched duty).
  - Duty 0: EN stays 0 in FWD/REV.
  - Duty 2^PWM_WIDTH-1: EN high for 2^PWM_WIDTH-1 of 2^PWM_WIDTH clocks.
  - The PWM counter keeps running in all states and is not reset by FSM transitions.
- Safety invariant: the output pair IN1/IN2 never goes 10 -> 01 or 01 -> 10 without at least DEADTIME_CYCLES clocks of IN1=IN2=0 between them.
- Reset mid-operation forces the reset values asynchronously. After release the block coasts DEADTIME_CYCLES, then reaches BRAKE.

Test Plan:
Bench parameters: PWM_WIDTH=4, DEADTIME_CYCLES=4.
1. Reset then hold CONTROL=11 -> IN1/IN2/EN=000 and BUSY=1 for 4 clocks after release, then IN1/IN2/EN=111 and BUSY=0.
2. From BRAKE, CONTROL=01 and DUTY=4 -> two-cycle latency, then 4 clocks of IN=00, EN=0. Then IN1=1, IN2=0, with EN high 4 of every 16 clocks, aligned to PWM counter 0..3.
3. Steady FWD, CONTROL 01->10 -> exactly 4 clocks of IN=00, EN=0, BUSY=1, then IN1=0, IN2=1. No cycle ever shows IN=01 adjacent to IN=10.
4. In DEAD (target REV) after 2 clocks, CONTROL=01 -> counter restarts; DEAD lasts 4 more clocks, then FWD. Separately, in DEAD apply CONTROL=11 -> BRAKE (111) at the second edge.
5. FWD, DUTY changes 4->12 at PWM counter 7 -> the rest of that period still uses duty 4; the next period has EN high for 12 clocks. DUTY=0 gives EN=0 constantly; DUTY=15 gives EN low 1 of 16 clocks.
6. Assert reset while in REV with PWM high -> IN1/IN2/EN go to 000 immediately, without a clock edge.
